// File: rtl/status_led_sched.sv
// status_led_sched: shares one status LED between error blink codes, activity
// flashes and a free-running heartbeat, sequencing every pattern on a slow tick.
module status_led_sched #(
    parameter int TICK_DIV  = 5000000,
    parameter int HB_TICKS  = 5,
    parameter int ACT_TICKS = 1,
    parameter int CODE_ON   = 3,
    parameter int CODE_OFF  = 3,
    parameter int CODE_GAP  = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hb_en,
    input  logic       act_pulse,
    input  logic [3:0] err_code,
    output logic       led,
    output logic [1:0] owner,
    output logic       busy
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DIV_W   = $clog2(TICK_DIV);
    localparam int HB_W    = $clog2(HB_TICKS + 1);
    localparam int TMR_MAX = max2(max2(ACT_TICKS, CODE_ON), max2(CODE_OFF, CODE_GAP));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HB_TICKS - 1);
    localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] T_ACT    = TMR_W'(ACT_TICKS);
    localparam logic [TMR_W-1:0] T_ON     = TMR_W'(CODE_ON);
    localparam logic [TMR_W-1:0] T_OFF    = TMR_W'(CODE_OFF);
    localparam logic [TMR_W-1:0] T_GAP    = TMR_W'(CODE_GAP);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_HB   = 2'b01;
    localparam logic [1:0] OWN_ACT  = 2'b10;
    localparam logic [1:0] OWN_ERR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERR_ON  = 3'd1,
        S_ERR_OFF = 3'd2,
        S_ERR_GAP = 3'd3,
        S_ACT_ON  = 3'd4,
        S_ACT_OFF = 3'd5
    } state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic [HB_W-1:0]  r_hb_cnt;
    logic             r_hb_phase;
    logic             r_act_pend;
    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [3:0]       r_blinks;
    logic             r_led;
    logic [1:0]       r_owner;
    logic             r_busy;

    logic             w_tick;
    logic             w_hb_wrap;
    logic             w_hb_phase_nxt;
    logic             w_act_req;
    logic             w_timer_last;
    logic             w_eval;
    logic             w_act_grant;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [3:0]       w_blinks_nxt;
    logic             w_led_nxt;
    logic [1:0]       w_owner_nxt;
    logic             w_busy_nxt;
    logic             w_act_pend_nxt;

    assign w_tick         = (r_div_cnt == DIV_LAST);
    assign w_hb_wrap      = w_tick && (r_hb_cnt == HB_LAST);
    assign w_hb_phase_nxt = r_hb_phase ^ w_hb_wrap;
    // A pulse landing on its own grant tick is consumed by that grant.
    assign w_act_req      = r_act_pend | act_pulse;
    assign w_timer_last   = (r_timer == T_ONE);

    assign led   = r_led;
    assign owner = r_owner;
    assign busy  = r_busy;

    // Tick divider and free-running heartbeat phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_hb_cnt   <= '0;
            r_hb_phase <= 1'b0;
        end else begin
            r_div_cnt  <= w_tick ? '0 : (r_div_cnt + 1'b1);
            r_hb_phase <= w_hb_phase_nxt;
            if (w_tick) begin
                r_hb_cnt <= w_hb_wrap ? '0 : (r_hb_cnt + 1'b1);
            end
        end
    end

    // Next-state, phase timer and output decode for the LED owner FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_blinks_nxt   = r_blinks;
        w_led_nxt      = r_led;
        w_owner_nxt    = r_owner;
        w_eval         = 1'b0;
        w_act_grant    = 1'b0;
        w_busy_nxt     = 1'b0;
        w_act_pend_nxt = r_act_pend;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    w_eval = 1'b1;
                end
                S_ERR_ON: begin
                    if (w_timer_last) begin
                        w_blinks_nxt = r_blinks - 4'd1;
                        w_led_nxt    = 1'b0;
                        if (r_blinks == 4'd1) begin
                            w_state_nxt = S_ERR_GAP;
                            w_timer_nxt = T_GAP;
                        end else begin
                            w_state_nxt = S_ERR_OFF;
                            w_timer_nxt = T_OFF;
                        end
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                S_ERR_OFF: begin
                    if (w_timer_last) begin
                        w_state_nxt = S_ERR_ON;
                        w_timer_nxt = T_ON;
                        w_led_nxt   = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                S_ACT_ON: begin
                    if (w_timer_last) begin
                        w_state_nxt = S_ACT_OFF;
                        w_timer_nxt = T_ACT;
                        w_led_nxt   = 1'b0;
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                S_ERR_GAP, S_ACT_OFF: begin
                    if (w_timer_last) begin
                        w_eval = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer - T_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_led_nxt   = 1'b0;
                    w_owner_nxt = OWN_NONE;
                end
            endcase
            // Grant evaluation, shared by IDLE and the last tick of a sequence.
            if (w_eval) begin
                if (err_code != 4'd0) begin
                    w_state_nxt  = S_ERR_ON;
                    w_timer_nxt  = T_ON;
                    w_blinks_nxt = err_code;
                    w_led_nxt    = 1'b1;
                    w_owner_nxt  = OWN_ERR;
                end else if (w_act_req) begin
                    w_state_nxt  = S_ACT_ON;
                    w_timer_nxt  = T_ACT;
                    w_led_nxt    = 1'b1;
                    w_owner_nxt  = OWN_ACT;
                    w_act_grant  = 1'b1;
                end else begin
                    w_state_nxt  = S_IDLE;
                    w_timer_nxt  = '0;
                    w_led_nxt    = hb_en & w_hb_phase_nxt;
                    w_owner_nxt  = hb_en ? OWN_HB : OWN_NONE;
                end
            end else begin
                w_act_grant = 1'b0;
            end
        end else begin
            w_state_nxt = r_state;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        if (w_act_grant) begin
            w_act_pend_nxt = 1'b0;
        end else if (act_pulse) begin
            w_act_pend_nxt = 1'b1;
        end else begin
            w_act_pend_nxt = r_act_pend;
        end
    end

    // FSM state, sequencing counters and registered LED outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_blinks   <= 4'd0;
            r_act_pend <= 1'b0;
            r_led      <= 1'b0;
            r_owner    <= OWN_NONE;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_blinks   <= w_blinks_nxt;
            r_act_pend <= w_act_pend_nxt;
            r_led      <= w_led_nxt;
            r_owner    <= w_owner_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_status_led_sched.sv
// Bench for status_led_sched: directed scenarios plus random traffic, checked
// against a tick-level model built from (led, duration) segment queues.
module tb_status_led_sched;

    localparam int TD   = 4;
    localparam int HB   = 2;
    localparam int AT   = 1;
    localparam int CON  = 2;
    localparam int COFF = 1;
    localparam int CGAP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hb_en = 1'b0;
    logic       act_pulse = 1'b0;
    logic [3:0] err_code = 4'd0;
    logic       led;
    logic [1:0] owner;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int   m_cyc, m_ticks, cur_left;
    bit   m_active, m_pend, cur_led;
    logic m_led, m_busy;
    logic [1:0] m_owner;
    int   q_len[$];
    bit   q_led[$];

    status_led_sched #(
        .TICK_DIV(TD), .HB_TICKS(HB), .ACT_TICKS(AT),
        .CODE_ON(CON), .CODE_OFF(COFF), .CODE_GAP(CGAP)
    ) dut (
        .clk(clk), .reset(reset), .hb_en(hb_en), .act_pulse(act_pulse),
        .err_code(err_code), .led(led), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cyc = 0; m_ticks = 0; cur_left = 0;
        m_active = 0; m_pend = 0; cur_led = 0;
        m_led = 1'b0; m_owner = 2'b00; m_busy = 1'b0;
        q_len.delete(); q_led.delete();
    endtask

    task automatic model_pop();
        cur_led = q_led.pop_front();
        cur_left = q_len.pop_front();
        m_led = cur_led;
        m_active = 1; m_busy = 1'b1;
    endtask

    task automatic model_grant();
        int n;
        n = err_code;
        if (n != 0) begin
            for (int i = 1; i <= n; i++) begin
                q_led.push_back(1); q_len.push_back(CON);
                q_led.push_back(0); q_len.push_back((i == n) ? CGAP : COFF);
            end
            m_owner = 2'b11;
            model_pop();
        end else if (m_pend) begin
            m_pend = 0;
            q_led.push_back(1); q_len.push_back(AT);
            q_led.push_back(0); q_len.push_back(AT);
            m_owner = 2'b10;
            model_pop();
        end else begin
            m_active = 0; m_busy = 1'b0;
            m_owner = hb_en ? 2'b01 : 2'b00;
            m_led = hb_en & (((m_ticks / HB) % 2) == 1);
        end
    endtask

    // One clock edge of the model, using the inputs the DUT saw at that edge.
    task automatic model_step();
        if (act_pulse) m_pend = 1;
        if ((m_cyc % TD) == TD - 1) begin
            m_ticks++;
            if (m_active) begin
                cur_left--;
                if (cur_left == 0) begin
                    if (q_len.size() > 0) model_pop();
                    else m_active = 0;
                end
            end
            if (!m_active) model_grant();
        end
        m_cyc++;
    endtask

    task automatic cycle(input logic hb, input logic pulse, input logic [3:0] code);
        hb_en = hb; act_pulse = pulse; err_code = code;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({led, owner, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_vals got %b exp 0000", {led, owner, busy});
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 4'd0);
            n_cmp++;
            if ({led, owner, busy} !== 4'b0000) begin
                n_bad++; $display("FAIL pre_tick c=%0d got %b exp 0000", i + 1, {led, owner, busy});
            end
        end
    endtask

    task automatic test_heartbeat();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 4'd0);
            e = {1'(((i + 1) / 8) % 2), ((i + 1) >= 4) ? 2'b01 : 2'b00, 1'b0};
            n_cmp++;
            if ({led, owner, busy} !== e) begin
                n_bad++; $display("FAIL heartbeat c=%0d got %b exp %b", i + 1, {led, owner, busy}, e);
            end
        end
    endtask

    task automatic test_err_code3();
        logic [3:0] e;
        int t;
        do_reset();
        for (int i = 0; i < 180; i++) begin
            cycle(1'b0, 1'b0, 4'd3);
            if (i + 1 >= 4) begin
                t = (i + 1 - 4) % 44;
                e = {((t < 8) || (t >= 12 && t < 20) || (t >= 24 && t < 32)), 2'b11, 1'b1};
            end else begin
                e = 4'b0000;
            end
            n_cmp++;
            if ({led, owner, busy} !== e) begin
                n_bad++; $display("FAIL err_code3 c=%0d got %b exp %b", i + 1, {led, owner, busy}, e);
            end
        end
    endtask

    task automatic test_single_act();
        logic [3:0] e;
        int c;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cycle(1'b0, (i == 5) || (i == 23), 4'd0);
            c = i + 1;
            if ((c >= 8 && c < 16) || (c >= 24 && c < 32))
                e = {((c >= 8 && c < 12) || (c >= 24 && c < 28)), 2'b10, 1'b1};
            else
                e = 4'b0000;
            n_cmp++;
            if ({led, owner, busy} !== e) begin
                n_bad++; $display("FAIL single_act c=%0d got %b exp %b", c, {led, owner, busy}, e);
            end
        end
    endtask

    task automatic test_code_change();
        int rises;
        logic prev;
        rises = 0; prev = 1'b0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b0, (i < 6) ? 4'd2 : ((i < 60) ? 4'd5 : 4'd0));
            if (led && !prev && owner == 2'b11) rises++;
            prev = led;
            n_cmp++;
            if ({led, owner, busy} !== {m_led, m_owner, m_busy}) begin
                n_bad++; $display("FAIL code_change c=%0d got %b exp %b", i + 1, {led, owner, busy}, {m_led, m_owner, m_busy});
            end
        end
        n_cmp++;
        if (rises !== 7) begin
            n_bad++; $display("FAIL code_change_blinks got %0d exp 7", rises);
        end
        n_cmp++;
        if ({owner, busy} !== 3'b000) begin
            n_bad++; $display("FAIL code_change_idle got %b exp 000", {owner, busy});
        end
    endtask

    task automatic test_act_during_err();
        int flashes;
        logic prev;
        flashes = 0; prev = 1'b0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, (i == 6) || (i == 14) || (i == 20), (i < 25) ? 4'd2 : 4'd0);
            if (led && !prev && owner == 2'b10) flashes++;
            prev = led;
            if (i + 1 == 36) begin
                n_cmp++;
                if ({led, owner, busy} !== 4'b1101) begin
                    n_bad++; $display("FAIL act_after_gap got %b exp 1101", {led, owner, busy});
                end
            end
            n_cmp++;
            if ({led, owner, busy} !== {m_led, m_owner, m_busy}) begin
                n_bad++; $display("FAIL act_during_err c=%0d got %b exp %b", i + 1, {led, owner, busy}, {m_led, m_owner, m_busy});
            end
        end
        n_cmp++;
        if (flashes !== 1) begin
            n_bad++; $display("FAIL act_flash_count got %0d exp 1", flashes);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 4'd3);
        n_cmp++;
        if ({led, owner, busy} !== 4'b1111) begin
            n_bad++; $display("FAIL mid_err_on got %b exp 1111", {led, owner, busy});
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({led, owner, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL async_reset got %b exp 0000", {led, owner, busy});
        end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, 4'd0);
            e = {1'(((i + 1) / 8) % 2), ((i + 1) >= 4) ? 2'b01 : 2'b00, 1'b0};
            n_cmp++;
            if ({led, owner, busy} !== e) begin
                n_bad++; $display("FAIL post_reset_hb c=%0d got %b exp %b", i + 1, {led, owner, busy}, e);
            end
        end
    endtask

    task automatic test_random();
        logic hb;
        logic [3:0] code;
        hb = 1'b1; code = 4'd0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0)
                code = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 199) == 0) hb = ~hb;
            cycle(hb, ($urandom_range(0, 19) == 0), code);
            n_cmp++;
            if ({led, owner, busy} !== {m_led, m_owner, m_busy}) begin
                n_bad++; $display("FAIL random c=%0d got %b exp %b", i + 1, {led, owner, busy}, {m_led, m_owner, m_busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_err_code3();
        test_single_act();
        test_code_change();
        test_act_during_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
